// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal register (hold/load/shift/rotate/clear)
// with a burst FSM that performs N serial shifts from a single start pulse.
module univ_shift_reg #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [2:0]       i_mode,
   input  logic [WIDTH-1:0] i_d_in,
   input  logic             i_sin_r,
   input  logic             i_sin_l,
   input  logic             i_start,
   input  logic             i_dir,
   input  logic [CW-1:0]    i_shift_cnt,
   output logic [WIDTH-1:0] o_q,
   output logic             o_sout_msb,
   output logic             o_sout_lsb,
   output logic             o_busy,
   output logic             o_done
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_rem;
   logic             r_dir;
   logic             r_done;
   logic [WIDTH-1:0] w_shl;
   logic [WIDTH-1:0] w_shr;
   logic [WIDTH-1:0] w_mode_q;
   assign w_shl = {r_q[WIDTH-2:0], i_sin_r};
   assign w_shr = {i_sin_l, r_q[WIDTH-1:1]};
   always_comb
      w_mode_q = (i_mode == 3'b001) ? i_d_in :
                 (i_mode == 3'b010) ? w_shl :
                 (i_mode == 3'b011) ? w_shr :
                 (i_mode == 3'b100) ? {r_q[WIDTH-2:0], r_q[WIDTH-1]} :
                 (i_mode == 3'b101) ? {r_q[0], r_q[WIDTH-1:1]} :
                 (i_mode == 3'b110) ? '0 : r_q;
   // r_rem holds shifts still to do after the current edge; the burst ends when it reaches zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_q     <= '0;
         r_rem   <= '0;
         r_dir   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == SHIFT) begin
            r_q   <= r_dir ? w_shr : w_shl;
            r_rem <= r_rem - CW'(1);
            if (r_rem == CW'(1)) begin
               r_state <= IDLE;
               r_done  <= 1'b1;
            end
         end else if (i_start) begin
            if (i_shift_cnt == '0) begin
               r_done <= 1'b1;
            end else begin
               r_q   <= i_dir ? w_shr : w_shl;
               r_rem <= i_shift_cnt - CW'(1);
               r_dir <= i_dir;
               if (i_shift_cnt == CW'(1)) r_done <= 1'b1;
               else r_state <= SHIFT;
            end
         end else begin
            r_q <= w_mode_q;
         end
      end
   end
   assign o_q        = r_q;
   assign o_sout_msb = r_q[WIDTH-1];
   assign o_sout_lsb = r_q[0];
   assign o_busy     = (r_state == SHIFT);
   assign o_done     = r_done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: vector table, directed burst sequences and random stimulus
// checked against a count-based behavioural model of the register.
module tb_univ_shift_reg;
   localparam int W  = 8;
   localparam int CW = 4;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    mode = 3'b000;
   logic [W-1:0]  d_in = '0;
   logic          sin_r = 1'b0, sin_l = 1'b0, start = 1'b0, dir = 1'b0;
   logic [CW-1:0] cnt = '0;
   logic [W-1:0]  q;
   logic          sout_msb, sout_lsb, busy, done;
   int            checks = 0, failures = 0;
   logic [W-1:0]  m_q = '0;
   int            m_rem = 0;
   bit            m_dir = 1'b0, m_done = 1'b0;

   univ_shift_reg #(.WIDTH(W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_d_in(d_in),
      .i_sin_r(sin_r), .i_sin_l(sin_l), .i_start(start), .i_dir(dir),
      .i_shift_cnt(cnt), .o_q(q), .o_sout_msb(sout_msb), .o_sout_lsb(sout_lsb),
      .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] f_shift(input logic [W-1:0] v, input bit right);
      return right ? ((v >> 1) | (W'(sin_l) << (W - 1))) : ((v << 1) | W'(sin_r));
   endfunction

   // reference: a burst is just a number of pending shifts; busy whenever more are pending
   task automatic model_edge();
      m_done = 1'b0;
      if (m_rem > 0) begin
         m_q = f_shift(m_q, m_dir);
         m_rem--;
         m_done = (m_rem == 0);
      end else if (start) begin
         if (cnt == 0) m_done = 1'b1;
         else begin
            m_q   = f_shift(m_q, dir);
            m_dir = dir;
            m_rem = int'(cnt) - 1;
            m_done = (m_rem == 0);
         end
      end else begin
         case (mode)
            3'b001: m_q = d_in;
            3'b010: m_q = f_shift(m_q, 1'b0);
            3'b011: m_q = f_shift(m_q, 1'b1);
            3'b100: m_q = (m_q << 1) | (m_q >> (W - 1));
            3'b101: m_q = (m_q >> 1) | (m_q << (W - 1));
            3'b110: m_q = '0;
            default: ;
         endcase
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_q"}, 32'(q), 32'(m_q));
      chk({tag, "_busy"}, 32'(busy), 32'(m_rem > 0));
      chk({tag, "_done"}, 32'(done), 32'(m_done));
      chk({tag, "_msb"}, 32'(sout_msb), 32'(m_q[W-1]));
      chk({tag, "_lsb"}, 32'(sout_lsb), 32'(m_q[0]));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic mid_reset(input string tag);
      rst_n = 1'b0;
      #1;
      m_q = '0; m_rem = 0; m_done = 1'b0;
      chk({tag, "_rq"}, 32'(q), 32'h0);
      chk({tag, "_rbusy"}, 32'(busy), 32'h0);
      chk({tag, "_rdone"}, 32'(done), 32'h0);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [2:0]   mode;
      logic [W-1:0] d_in;
      logic         sin_r;
      logic         sin_l;
      logic [W-1:0] exp_q;
   } vec_t;
   vec_t vt[7];

   initial begin
      int nb, nd;
      vt[0] = '{3'b001, 8'hA5, 1'b0, 1'b0, 8'hA5};
      vt[1] = '{3'b100, 8'h00, 1'b0, 1'b0, 8'h4B};
      vt[2] = '{3'b101, 8'h00, 1'b0, 1'b0, 8'hA5};
      vt[3] = '{3'b010, 8'h00, 1'b1, 1'b0, 8'h4B};
      vt[4] = '{3'b011, 8'h00, 1'b0, 1'b0, 8'h25};
      vt[5] = '{3'b110, 8'hFF, 1'b1, 1'b1, 8'h00};
      vt[6] = '{3'b111, 8'hFF, 1'b1, 1'b1, 8'h00};
      #2;
      chk("reset_q", 32'(q), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // mode table
      for (int i = 0; i < 7; i++) begin
         mode = vt[i].mode; d_in = vt[i].d_in; sin_r = vt[i].sin_r; sin_l = vt[i].sin_l;
         tick("mode");
         chk($sformatf("mode_vec%0d", i), 32'(q), 32'(vt[i].exp_q));
      end
      // asynchronous reset with nonzero contents
      mode = 3'b001; d_in = 8'h3C;
      tick("preload");
      mode = 3'b000;
      mid_reset("async");
      // burst left N=3 from 81
      mode = 3'b001; d_in = 8'h81;
      tick("b3_load");
      mode = 3'b000; sin_r = 1'b0; start = 1'b1; dir = 1'b0; cnt = 4'd3;
      nb = 0; nd = 0;
      tick("b3");
      chk("b3_q1", 32'(q), 32'h02);
      start = 1'b0;
      nb += int'(busy); nd += int'(done);
      tick("b3");
      chk("b3_q2", 32'(q), 32'h04);
      nb += int'(busy); nd += int'(done);
      tick("b3");
      chk("b3_q3", 32'(q), 32'h08);
      nb += int'(busy); nd += int'(done);
      chk("b3_done_last", 32'(done), 32'h1);
      tick("b3");
      nb += int'(busy); nd += int'(done);
      chk("b3_busy_cycles", 32'(nb), 32'd2);
      chk("b3_done_pulses", 32'(nd), 32'd1);
      // N=0 and N=1
      start = 1'b1; cnt = 4'd0; mode = 3'b001; d_in = 8'hFF;
      tick("n0");
      chk("n0_q", 32'(q), 32'h08);
      chk("n0_done", 32'(done), 32'h1);
      chk("n0_busy", 32'(busy), 32'h0);
      cnt = 4'd1; dir = 1'b1; sin_l = 1'b1;
      tick("n1");
      chk("n1_q", 32'(q), 32'h84);
      chk("n1_done", 32'(done), 32'h1);
      chk("n1_busy", 32'(busy), 32'h0);
      start = 1'b0; mode = 3'b000;
      tick("n1_idle");
      // inputs ignored while busy, then reset mid-burst
      mode = 3'b001; d_in = 8'h0F;
      tick("ign_load");
      mode = 3'b000; start = 1'b1; dir = 1'b0; sin_r = 1'b1; cnt = 4'd6;
      tick("ign");
      mode = 3'b001; d_in = 8'hAA; dir = 1'b1; cnt = 4'd0;
      tick("ign");
      mode = 3'b110; start = 1'b0; d_in = 8'h55;
      tick("ign");
      chk("ign_q", 32'(q), 32'h7F);
      mid_reset("midburst");
      mode = 3'b000; start = 1'b0;
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         tick("post_rst");
         nd += int'(done);
      end
      chk("post_rst_no_done", 32'(nd), 32'd0);
      mode = 3'b001; d_in = 8'hC3;
      tick("restart_load");
      mode = 3'b000; start = 1'b1; dir = 1'b1; sin_l = 1'b0; cnt = 4'd2;
      tick("restart");
      start = 1'b0;
      tick("restart");
      chk("restart_q", 32'(q), 32'h30);
      chk("restart_done", 32'(done), 32'h1);
      // back-to-back bursts
      mode = 3'b001; d_in = 8'h3C;
      tick("b2b_load");
      mode = 3'b000; start = 1'b1; dir = 1'b1; sin_l = 1'b1; sin_r = 1'b0; cnt = 4'd2;
      nd = 0;
      tick("b2b"); nd += int'(done);
      start = 1'b0;
      tick("b2b"); nd += int'(done);
      chk("b2b_mid_q", 32'(q), 32'hCF);
      start = 1'b1; dir = 1'b0; cnt = 4'd2;
      tick("b2b"); nd += int'(done);
      start = 1'b0;
      tick("b2b"); nd += int'(done);
      tick("b2b"); nd += int'(done);
      chk("b2b_q", 32'(q), 32'h3C);
      chk("b2b_done_pulses", 32'(nd), 32'd2);
      // long burst beyond WIDTH
      start = 1'b1; dir = 1'b0; sin_r = 1'b1; cnt = 4'd15;
      tick("long");
      start = 1'b0; sin_r = 1'b0;
      for (int i = 0; i < 15; i++) tick("long");
      // randomized
      for (int i = 0; i < 400; i++) begin
         mode  = 3'($urandom);
         d_in  = 8'($urandom);
         sin_r = 1'($urandom);
         sin_l = 1'($urandom);
         start = ($urandom_range(0, 5) == 0);
         dir   = 1'($urandom);
         cnt   = 4'($urandom_range(0, 11));
         tick("rand");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
